// File: rtl/spi_reg_ctrl.sv
// Register-access controller behind the SPI slave byte engine: decodes command/data bytes into
// register-bus strobes and sequences the slave's transmit byte (read data appears in the next frame).
`timescale 1ns/1ps
module spi_reg_ctrl #(
    parameter logic [7:0] IDLE_BYTE = 8'hA5,
    parameter int         MAX_BURST = 16,
    parameter bit         AUTO_INC  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ss,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       err_sticky,
    input  logic       err_clr
);

    localparam int             CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RD   = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          ss_meta;
    logic          ss_s;
    logic          ss_s_d;
    logic          rx_valid_d;
    logic          rd_cap;
    logic          byte_stb;
    logic          frame_start;
    logic          frame_end;
    logic          err_set;

    assign byte_stb    = rx_valid & ~rx_valid_d;
    assign frame_start = ss_s_d & ~ss_s;
    assign frame_end   = ~ss_s_d & ss_s;
    assign err_set     = (state == S_WR) && byte_stb && (count >= CNT_MAX);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= '0;
            ss_meta    <= 1'b1;
            ss_s       <= 1'b1;
            ss_s_d     <= 1'b1;
            rx_valid_d <= 1'b0;
            rd_cap     <= 1'b0;
            tx_byte    <= IDLE_BYTE;
            reg_addr   <= 7'd0;
            reg_wdata  <= 8'd0;
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            ss_meta    <= ss;
            ss_s       <= ss_meta;
            ss_s_d     <= ss_s;
            rx_valid_d <= rx_valid;
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            // Read data arrives the cycle after the read strobe; capture it even if the frame has ended.
            rd_cap     <= reg_rd_en;
            if (rd_cap) begin
                tx_byte <= reg_rdata;
            end
            if (reg_wr_en && AUTO_INC) begin
                reg_addr <= reg_addr + 7'd1;
            end

            if (err_set) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (byte_stb) begin
                        reg_addr <= rx_byte[6:0];
                        tx_byte  <= IDLE_BYTE;
                        if (rx_byte[7]) begin
                            reg_rd_en <= 1'b1;
                            state     <= S_RD;
                        end else begin
                            count <= '0;
                            state <= S_WR;
                        end
                    end
                end
                S_WR: begin
                    if (byte_stb && (count < CNT_MAX)) begin
                        reg_wdata <= rx_byte;
                        reg_wr_en <= 1'b1;
                        count     <= count + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase

            // A byte landing with frame end is handled above first; the frame still closes here.
            if (frame_end && (state != S_IDLE)) begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized self-checking bench for spi_reg_ctrl: frame-level model predicts bus transactions,
// transmit byte and error flag; a negedge monitor scores every strobe against the expectation queues.
`timescale 1ns/1ps
module tb_spi_reg_ctrl;

    localparam logic [7:0] IDLE_BYTE = 8'hA5;
    localparam int         MAX_BURST = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic [7:0] tx_byte;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rdata = 8'd0;
    logic       busy;
    logic       err_sticky;
    logic       err_clr = 1'b0;

    int total = 0;
    int bad = 0;

    logic [14:0] wr_exp[$];
    logic [6:0]  rd_exp[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  rd_value = 8'h00;
    logic [7:0]  exp_tx = IDLE_BYTE;
    logic        exp_err = 1'b0;
    logic        wr_prev = 1'b0;
    logic        rd_prev = 1'b0;
    logic        rd_seen = 1'b0;

    spi_reg_ctrl #(
        .IDLE_BYTE (IDLE_BYTE),
        .MAX_BURST (MAX_BURST),
        .AUTO_INC  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss         (ss),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .tx_byte    (tx_byte),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_en  (reg_rd_en),
        .reg_rdata  (reg_rdata),
        .busy       (busy),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Register file answers only in the cycle after the read strobe; garbage otherwise.
    always @(negedge clk) begin
        reg_rdata = rd_seen ? rd_value : ~rd_value;
        rd_seen   = reg_rd_en;
    end

    always @(negedge clk) begin
        logic [14:0] we;
        logic [6:0]  re;
        if (reg_wr_en) begin
            checkOutput("wr_expected", 32'(wr_exp.size() > 0), 32'd1);
            checkOutput("wr_rd_excl", 32'(reg_rd_en), 32'd0);
            checkOutput("wr_one_cycle", 32'(wr_prev), 32'd0);
            if (wr_exp.size() > 0) begin
                we = wr_exp.pop_front();
                checkOutput("wr_addr", 32'(reg_addr), 32'(we[14:8]));
                checkOutput("wr_data", 32'(reg_wdata), 32'(we[7:0]));
            end
        end
        if (reg_rd_en) begin
            checkOutput("rd_expected", 32'(rd_exp.size() > 0), 32'd1);
            checkOutput("rd_one_cycle", 32'(rd_prev), 32'd0);
            if (rd_exp.size() > 0) begin
                re = rd_exp.pop_front();
                checkOutput("rd_addr", 32'(reg_addr), 32'(re));
            end
        end
        wr_prev = reg_wr_en;
        rd_prev = reg_rd_en;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        exp_err = 1'b0;
        checkOutput("err_cleared", 32'(err_sticky), 32'd0);
    endtask

    // Predicts a whole frame from frame_q, then drives it and checks the post-frame state.
    task automatic applyStimulus();
        logic [7:0] cmd;
        logic [7:0] tx_next;
        tx_next = exp_tx;
        if (frame_q.size() > 0) begin
            cmd = frame_q[0];
            if (cmd[7]) begin
                rd_exp.push_back(cmd[6:0]);
                tx_next = rd_value;
            end else begin
                tx_next = IDLE_BYTE;
                for (int i = 1; i < frame_q.size(); i++) begin
                    if (i <= MAX_BURST)
                        wr_exp.push_back({7'((int'(cmd[6:0]) + i - 1) % 128), frame_q[i]});
                    else
                        exp_err = 1'b1;
                end
            end
        end
        ss = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("busy_in_frame", 32'(busy), 32'd1);
        checkOutput("tx_at_start", 32'(tx_byte), 32'(exp_tx));
        foreach (frame_q[i]) send_byte(frame_q[i]);
        ss = 1'b1;
        repeat (5) @(negedge clk);
        exp_tx = tx_next;
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("tx_after", 32'(tx_byte), 32'(exp_tx));
        checkOutput("err_after", 32'(err_sticky), 32'(exp_err));
        checkOutput("wr_left", 32'(wr_exp.size()), 32'd0);
        checkOutput("rd_left", 32'(rd_exp.size()), 32'd0);
    endtask

    task automatic check_reset_values();
        checkOutput("rst_tx", 32'(tx_byte), 32'(IDLE_BYTE));
        checkOutput("rst_addr", 32'(reg_addr), 32'd0);
        checkOutput("rst_wdata", 32'(reg_wdata), 32'd0);
        checkOutput("rst_wr_en", 32'(reg_wr_en), 32'd0);
        checkOutput("rst_rd_en", 32'(reg_rd_en), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err_sticky), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind;
        int len;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] burst write with auto-increment");
        frame_q = '{8'h05, 8'h11, 8'h22, 8'h33};
        applyStimulus();

        $display("[TB] read, data returned in next frame");
        rd_value = 8'h5C;
        frame_q = '{8'h85};
        applyStimulus();

        $display("[TB] address wrap");
        frame_q = '{8'h7F, 8'hAA, 8'hBB};
        applyStimulus();

        $display("[TB] burst overflow");
        frame_q = '{8'h40};
        for (int i = 0; i < MAX_BURST + 2; i++) frame_q.push_back(8'($urandom));
        applyStimulus();
        pulse_err_clr();

        $display("[TB] frame aborted before a data byte completes");
        frame_q = '{8'h20};
        applyStimulus();
        frame_q = '{8'h21, 8'h9E};
        applyStimulus();

        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(0, MAX_BURST + 3);
            frame_q = {};
            if (kind != 0) begin
                frame_q.push_back({(kind <= 3) ? 1'b1 : 1'b0, 7'($urandom)});
                for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
            end
            rd_value = 8'($urandom);
            applyStimulus();
            if ($urandom_range(0, 3) == 0) pulse_err_clr();
        end

        $display("[TB] reset in the middle of a write burst");
        ss = 1'b0;
        repeat (4) @(negedge clk);
        wr_exp.push_back({7'h30, 8'h01});
        send_byte(8'h30);
        send_byte(8'h01);
        rx_byte  = 8'h02;
        rx_valid = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        check_reset_values();
        ss       = 1'b1;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_tx  = IDLE_BYTE;
        exp_err = 1'b0;
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_wr_left", 32'(wr_exp.size()), 32'd0);
        frame_q = '{8'h11, 8'h77};
        applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
